// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// then answers with a single-cycle ready strobe carrying byte-masked read data or an error.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  be,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          mw_r;
  logic [31:0]   addr_r, wdata_r;
  logic [3:0]    be_r;
  logic [31:0]   mem_r [DEPTH];

  logic          txn_mw_s, txn_err_s, we_s;
  logic [31:0]   txn_addr_s, txn_wdata_s;
  logic [3:0]    txn_be_s;
  logic [AW-1:0] txn_idx_s;
  logic [31:0]   rdata_s;
  logic          ready_s, busy_s, err_s;

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // state register and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // request capture on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
    end else if (state_r == S_IDLE && req) begin
      mw_r    <= MemWrite;
      addr_r  <= addr;
      wdata_r <= WriteData;
      be_r    <= be;
    end else begin
      mw_r    <= mw_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // next-state and counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_s = S_WAIT;
            cnt_s   = WS_LOAD;
          end else begin
            state_s = S_RESP;
            cnt_s   = 4'd0;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // With zero wait states the response edge is also the accepting edge, so use live inputs in IDLE
  always_comb begin
    if (state_r == S_IDLE) begin
      txn_mw_s    = MemWrite;
      txn_addr_s  = addr;
      txn_wdata_s = WriteData;
      txn_be_s    = be;
    end else begin
      txn_mw_s    = mw_r;
      txn_addr_s  = addr_r;
      txn_wdata_s = wdata_r;
      txn_be_s    = be_r;
    end
    txn_idx_s = txn_addr_s[AW+1:2];
    txn_err_s = (txn_addr_s[1:0] != 2'b00) || (txn_addr_s[31:2] >= 30'(DEPTH));
    we_s      = reset && (state_s == S_RESP) && txn_mw_s && !txn_err_s;
  end

  // output values for the cycle that follows the coming edge
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    err_s   = 1'b0;
    rdata_s = 32'd0;
    case (state_s)
      S_IDLE: busy_s = 1'b0;
      S_WAIT: busy_s = 1'b1;
      S_RESP: begin
        busy_s  = 1'b1;
        ready_s = 1'b1;
        err_s   = txn_err_s;
        if (!txn_mw_s && !txn_err_s) begin
          rdata_s = mem_r[txn_idx_s] & lane_mask(txn_be_s);
        end else begin
          rdata_s = 32'd0;
        end
      end
      default: busy_s = 1'b0;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ReadData <= 32'd0;
    end else begin
      ready    <= ready_s;
      busy     <= busy_s;
      err      <= err_s;
      ReadData <= rdata_s;
    end
  end

  // data array, intentionally not reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (txn_be_s[k]) begin
          mem_r[txn_idx_s][8*k +: 8] <= txn_wdata_s[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

  logic        clk, reset, req, req0, MemWrite;
  logic [31:0] addr, WriteData, rdata, rdata0;
  logic [3:0]  be;
  logic        ready, busy, err, ready0, busy0, err0;
  int          passed, total;

  dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .MemWrite(MemWrite), .addr(addr),
    .WriteData(WriteData), .be(be), .ReadData(rdata), .ready(ready), .busy(busy), .err(err));

  dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .MemWrite(MemWrite), .addr(addr),
    .WriteData(WriteData), .be(be), .ReadData(rdata0), .ready(ready0), .busy(busy0), .err(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = cycles from accepting edge to the ready cycle (1 means the cycle right after the edge), -1 on timeout
  task automatic do_req(input bit sel, input bit mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output int lat, output logic e, output logic [31:0] rd);
    int k;
    k = 0;
    while ((sel ? busy0 : busy) && k < 50) begin @(posedge clk); #1; k++; end
    MemWrite = mw; addr = a; WriteData = wd; be = b;
    if (sel) req0 = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; req0 = 1'b0;
    k = 0;
    while (!(sel ? ready0 : ready) && k < 50) begin @(posedge clk); #1; k++; end
    lat = (k >= 50) ? -1 : k + 1;
    e   = sel ? err0 : err;
    rd  = sel ? rdata0 : rdata;
  endtask

  task automatic test_reset();
    total++; if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL rst_busy0 got %b want 0", busy0); else passed++;
  endtask

  task automatic test_write_read();
    int lat; logic e; logic [31:0] rd;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, e, rd);
    total++; if (lat !== 3) $display("FAIL wr_lat got %0d want 3", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL wr_rdata got %h want 0", rd); else passed++;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd);
    total++; if (lat !== 3) $display("FAIL rd_lat got %0d want 3", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL rd_err got %b want 0", e); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_byte_enable();
    int lat; logic e; logic [31:0] rd;
    do_req(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, e, rd);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd);
    total++; if (rd !== 32'hDEADBEAA) $display("FAIL be_lane0 got %h want deadbeaa", rd); else passed++;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'b0100, lat, e, rd);
    total++; if (rd !== 32'h00AD0000) $display("FAIL be_rdmask got %h want 00ad0000", rd); else passed++;
    do_req(1'b0, 1'b1, 32'h10, 32'h55555555, 4'b0000, lat, e, rd);
    total++; if (lat !== 3) $display("FAIL be0_lat got %0d want 3", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL be0_err got %b want 0", e); else passed++;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd);
    total++; if (rd !== 32'hDEADBEAA) $display("FAIL be0_nochange got %h want deadbeaa", rd); else passed++;
  endtask

  task automatic test_errors();
    int lat; logic e; logic [31:0] rd;
    do_req(1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, lat, e, rd);
    do_req(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, lat, e, rd);
    total++; if (lat !== 3) $display("FAIL mis_lat got %0d want 3", lat); else passed++;
    total++; if (e !== 1'b1) $display("FAIL mis_err got %b want 1", e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL mis_rdata got %h want 0", rd); else passed++;
    do_req(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, lat, e, rd);
    total++; if (e !== 1'b1) $display("FAIL oor_err got %b want 1", e); else passed++;
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, lat, e, rd);
    total++; if (rd !== 32'h11223344) $display("FAIL oor_word0 got %h want 11223344", rd); else passed++;
    do_req(1'b0, 1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, lat, e, rd);
    total++; if (e !== 1'b0) $display("FAIL top_wr_err got %b want 0", e); else passed++;
    do_req(1'b0, 1'b0, 32'hFC, 32'h0, 4'hF, lat, e, rd);
    total++; if (rd !== 32'hA5A5A5A5) $display("FAIL top_rd got %h want a5a5a5a5", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int k; int pulses; logic [11:0] rdy_mask, idle_mask; logic data_ok;
    k = 0;
    while (busy && k < 50) begin @(posedge clk); #1; k++; end
    MemWrite = 1'b0; addr = 32'h10; be = 4'hF; req = 1'b1;
    pulses = 0; rdy_mask = 12'h0; idle_mask = 12'h0; data_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy_mask[i]  = ready;
      idle_mask[i] = ~busy;
      if (ready) begin
        pulses++;
        if (rdata !== 32'hDEADBEAA) data_ok = 1'b0;
      end
      if (i == 11) req = 1'b0;
      @(posedge clk); #1;
    end
    req = 1'b0;
    total++; if (pulses !== 3) $display("FAIL b2b_pulses got %0d want 3", pulses); else passed++;
    total++; if (rdy_mask !== 12'h888) $display("FAIL b2b_ready_cycles got %h want 888", rdy_mask); else passed++;
    total++; if (idle_mask !== 12'h111) $display("FAIL b2b_busy_low got %h want 111", idle_mask); else passed++;
    total++; if (data_ok !== 1'b1) $display("FAIL b2b_data got %b want 1", data_ok); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat; logic e; logic [31:0] rd; int k;
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat, e, rd);
    k = 0;
    while (busy && k < 50) begin @(posedge clk); #1; k++; end
    MemWrite = 1'b1; addr = 32'h20; WriteData = 32'h12345678; be = 4'hF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL abort_inwait got %b want 1", busy); else passed++;
    reset = 1'b0; #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL abort_ready got %b want 0", ready); else passed++;
    total++; if ({err, rdata} !== 33'h0) $display("FAIL abort_err_data got %h want 0", {err, rdata}); else passed++;
    @(posedge clk); #2;
    reset = 1'b1;
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, lat, e, rd);
    total++; if (lat !== 3) $display("FAIL post_rst_lat got %0d want 3", lat); else passed++;
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL abort_discard got %h want cafef00d", rd); else passed++;
  endtask

  task automatic test_zero_wait();
    int lat; logic e; logic [31:0] rd;
    do_req(1'b1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, lat, e, rd);
    total++; if (lat !== 1) $display("FAIL ws0_wr_lat got %0d want 1", lat); else passed++;
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, e, rd);
    total++; if (lat !== 1) $display("FAIL ws0_rd_lat got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'h0BADF00D) $display("FAIL ws0_rd_data got %h want 0badf00d", rd); else passed++;
    @(posedge clk); #1;
    total++; if ({busy0, ready0} !== 2'b00) $display("FAIL ws0_resp_len got %b want 00", {busy0, ready0}); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; req = 1'b0; req0 = 1'b0; MemWrite = 1'b0;
    addr = 32'h0; WriteData = 32'h0; be = 4'h0;
    #1 reset = 1'b0;
    #10;
    test_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
